// File: rtl/load_store_unit_if.sv
// Data-memory bus between the load/store unit (master) and memory (slave).
// Master holds the request stable while mem_valid is high and mem_ready is low.
interface load_store_unit_if;
    logic        mem_valid;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;
    logic        mem_ready;

    modport master (
        output mem_valid, mem_we, mem_addr, mem_wdata, mem_wstrb,
        input  mem_rdata, mem_ready
    );

    modport slave (
        input  mem_valid, mem_we, mem_addr, mem_wdata, mem_wstrb,
        output mem_rdata, mem_ready
    );
endinterface

// File: rtl/load_store_unit.sv
// Load/store stage: one bus access per start, done 2 cycles after start on a zero-wait bus.
// Stalls while mem_ready is low, aborting with bus_err after BUS_TIMEOUT wait cycles.
module load_store_unit #(
    parameter int BUS_TIMEOUT = 255,
    parameter int TIMEOUT_W   = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     is_load,
    input  logic                     is_store,
    input  logic [2:0]               funct3,
    input  logic [31:0]              address,
    input  logic [31:0]              store_data,
    load_store_unit_if.master        bus,
    output logic [31:0]              load_result,
    output logic                     done,
    output logic                     misaligned,
    output logic                     bus_err
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]           state;
    logic [TIMEOUT_W-1:0] wait_cnt;
    logic [TIMEOUT_W-1:0] wait_cnt_nxt;
    logic                 timeout_hit;

    logic                 op_load;
    logic [2:0]           op_f3;
    logic [1:0]           op_lane;

    logic                 req_byte;
    logic                 req_half;
    logic                 req_word;
    logic                 req_mis;
    logic [3:0]           req_strb;
    logic [31:0]          req_wdata;

    logic [7:0]           ld_byte;
    logic [15:0]          ld_half;
    logic [31:0]          ld_ext;

    // funct3[1:0] selects the width; 10 and 11 (incl. undefined codes) are word accesses.
    always_comb begin
        req_byte  = (funct3[1:0] == 2'b00);
        req_half  = (funct3[1:0] == 2'b01);
        req_word  = funct3[1];
        req_mis   = (req_half & address[0]) | (req_word & (address[1:0] != 2'b00));
        req_strb  = 4'b1111;
        req_wdata = store_data;
        if (req_byte) begin
            req_strb  = 4'b0001 << address[1:0];
            req_wdata = {4{store_data[7:0]}};
        end else if (req_half) begin
            req_strb  = 4'b0011 << address[1:0];
            req_wdata = {2{store_data[15:0]}};
        end
    end

    always_comb begin
        ld_byte = bus.mem_rdata[{op_lane, 3'b000} +: 8];
        ld_half = op_lane[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
        case (op_f3)
            3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
            3'b100:  ld_ext = {24'd0, ld_byte};
            3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
            3'b101:  ld_ext = {16'd0, ld_half};
            default: ld_ext = bus.mem_rdata;
        endcase
    end

    assign wait_cnt_nxt = wait_cnt + TIMEOUT_W'(1);
    assign timeout_hit  = (BUS_TIMEOUT != 0) && (wait_cnt_nxt == TIMEOUT_W'(BUS_TIMEOUT));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            wait_cnt      <= '0;
            op_load       <= 1'b0;
            op_f3         <= 3'b000;
            op_lane       <= 2'b00;
            bus.mem_valid <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= 32'd0;
            bus.mem_wdata <= 32'd0;
            bus.mem_wstrb <= 4'b0000;
            load_result   <= 32'd0;
            done          <= 1'b0;
            misaligned    <= 1'b0;
            bus_err       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start && (is_load || is_store)) begin
                        op_load       <= is_load;
                        op_f3         <= funct3;
                        op_lane       <= address[1:0];
                        wait_cnt      <= '0;
                        bus_err       <= 1'b0;
                        bus.mem_addr  <= {address[31:2], 2'b00};
                        bus.mem_we    <= ~is_load;
                        bus.mem_wdata <= req_wdata;
                        bus.mem_wstrb <= is_load ? 4'b0000 : req_strb;
                        if (req_mis) begin
                            misaligned <= 1'b1;
                            done       <= 1'b1;
                            state      <= S_RESP;
                        end else begin
                            misaligned    <= 1'b0;
                            bus.mem_valid <= 1'b1;
                            state         <= S_REQ;
                        end
                    end
                end
                S_REQ: begin
                    if (bus.mem_ready) begin
                        if (op_load) begin
                            load_result <= ld_ext;
                        end
                        bus.mem_valid <= 1'b0;
                        done          <= 1'b1;
                        state         <= S_RESP;
                    end else if (timeout_hit) begin
                        bus.mem_valid <= 1'b0;
                        bus_err       <= 1'b1;
                        done          <= 1'b1;
                        state         <= S_RESP;
                    end else begin
                        wait_cnt <= wait_cnt_nxt;
                    end
                end
                S_RESP: begin
                    state <= S_IDLE;
                end
                default: begin
                    bus.mem_valid <= 1'b0;
                    state         <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;
    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        is_load;
    logic        is_store;
    logic [2:0]  funct3;
    logic [31:0] address;
    logic [31:0] store_data;
    logic [31:0] load_result;
    logic        done;
    logic        misaligned;
    logic        bus_err;

    always #5 clk = ~clk;

    load_store_unit_if bus ();

    load_store_unit #(.BUS_TIMEOUT(TMO), .TIMEOUT_W(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .is_load     (is_load),
        .is_store    (is_store),
        .funct3      (funct3),
        .address     (address),
        .store_data  (store_data),
        .bus         (bus),
        .load_result (load_result),
        .done        (done),
        .misaligned  (misaligned),
        .bus_err     (bus_err)
    );

    int          errors = 0;
    int          checks = 0;
    logic [31:0] model_lr;

    // observations of one access, filled by run_access
    int          o_valid;
    int          o_done_cyc;
    logic [31:0] o_addr;
    logic [31:0] o_wdata;
    logic [3:0]  o_wstrb;
    logic        o_we;
    logic        o_stable;
    logic [31:0] o_lr;
    logic        o_mis;
    logic        o_berr;
    logic        o_done_after;
    logic        o_mis_after;
    logic        o_berr_after;

    // 0 = byte, 1 = half, 2 = word
    function automatic int kind_of(input logic [2:0] f3);
        case (f3)
            3'd0, 3'd4: return 0;
            3'd1, 3'd5: return 1;
            default:    return 2;
        endcase
    endfunction

    function automatic logic exp_mis(input logic [2:0] f3, input logic [31:0] a);
        int k = kind_of(f3);
        if (k == 1) return (a % 2) != 0;
        if (k == 2) return (a % 4) != 0;
        return 1'b0;
    endfunction

    function automatic logic [3:0] exp_strb(input logic [2:0] f3, input logic [31:0] a);
        int k = kind_of(f3);
        int lane = int'(a % 4);
        if (k == 0) return 4'(1 << lane);
        if (k == 1) return 4'(3 << lane);
        return 4'hF;
    endfunction

    function automatic logic [31:0] exp_wdata(input logic [2:0] f3, input logic [31:0] sd);
        int k = kind_of(f3);
        if (k == 0) return (sd & 32'hFF) * 32'h0101_0101;
        if (k == 1) return (sd & 32'hFFFF) * 32'h0001_0001;
        return sd;
    endfunction

    function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] rd);
        int          k = kind_of(f3);
        logic [31:0] v;
        if (k == 0) begin
            v = (rd >> (8 * (a % 4))) & 32'hFF;
            if (f3 == 3'd0 && v >= 32'd128) v = v | 32'hFFFF_FF00;
            return v;
        end
        if (k == 1) begin
            v = (rd >> (16 * ((a / 2) % 2))) & 32'hFFFF;
            if (f3 == 3'd1 && v >= 32'h8000) v = v | 32'hFFFF_0000;
            return v;
        end
        return rd;
    endfunction

    // Entered and left just after a rising edge. Drives one start and acts as memory,
    // raising mem_ready in the (waits+1)-th request cycle.
    task automatic run_access(input logic ld, input logic st, input logic [2:0] f3,
                              input logic [31:0] addr, input logic [31:0] sd,
                              input logic [31:0] rd, input int waits);
        o_valid = 0; o_done_cyc = -1; o_stable = 1'b1; o_done_after = 1'b1;
        o_mis_after = 1'b0; o_berr_after = 1'b0; o_lr = 32'd0; o_mis = 1'b0; o_berr = 1'b0;
        o_addr = 32'd0; o_wdata = 32'd0; o_wstrb = 4'd0; o_we = 1'b0;
        start = 1'b1; is_load = ld; is_store = st; funct3 = f3;
        address = addr; store_data = sd; bus.mem_rdata = rd; bus.mem_ready = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); #1;
            start = 1'b0; is_load = 1'b0; is_store = 1'b0;
            bus.mem_ready = 1'b0;
            if (bus.mem_valid) begin
                if (o_valid == 0) begin
                    o_addr = bus.mem_addr; o_wdata = bus.mem_wdata;
                    o_wstrb = bus.mem_wstrb; o_we = bus.mem_we;
                end else if (o_addr !== bus.mem_addr || o_wdata !== bus.mem_wdata ||
                             o_wstrb !== bus.mem_wstrb || o_we !== bus.mem_we) begin
                    o_stable = 1'b0;
                end
                bus.mem_ready = (o_valid == waits);
                o_valid++;
            end
            @(negedge clk);
            if (o_done_cyc >= 0) begin
                o_done_after = done; o_mis_after = misaligned; o_berr_after = bus_err;
                break;
            end
            if (done) begin
                o_done_cyc = c; o_lr = load_result; o_mis = misaligned; o_berr = bus_err;
            end
        end
        @(posedge clk); #1;
        bus.mem_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; start = 1'b0; is_load = 1'b0; is_store = 1'b0; funct3 = 3'd0;
        address = 32'd0; store_data = 32'd0; bus.mem_rdata = 32'd0; bus.mem_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({bus.mem_valid, bus.mem_we, bus.mem_wstrb, done, misaligned, bus_err} !== 9'd0) begin
            errors++;
            $display("FAIL reset_ctrl got=%b exp=0", {bus.mem_valid, bus.mem_we, bus.mem_wstrb,
                     done, misaligned, bus_err});
        end
        checks++;
        if ({bus.mem_addr, bus.mem_wdata, load_result} !== 96'd0) begin
            errors++;
            $display("FAIL reset_data addr=%h wdata=%h lr=%h exp=0", bus.mem_addr,
                     bus.mem_wdata, load_result);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_lr = 32'd0;
        @(posedge clk); #1;
    endtask

    task automatic test_lw;
        run_access(1'b1, 1'b0, 3'b010, 32'h100, 32'd0, 32'hDEADBEEF, 0);
        checks++;
        if (o_addr !== 32'h100 || o_wstrb !== 4'b0000 || o_we !== 1'b0) begin
            errors++;
            $display("FAIL lw_bus addr=%h strb=%b we=%b exp 100/0000/0", o_addr, o_wstrb, o_we);
        end
        checks++;
        if (o_done_cyc !== 2 || o_valid !== 1) begin
            errors++;
            $display("FAIL lw_latency done=%0d valid=%0d exp 2/1", o_done_cyc, o_valid);
        end
        checks++;
        if (o_lr !== 32'hDEADBEEF || o_done_after !== 1'b0) begin
            errors++;
            $display("FAIL lw_result lr=%h done_after=%b exp deadbeef/0", o_lr, o_done_after);
        end
        model_lr = 32'hDEADBEEF;
    endtask

    task automatic test_load_ext;
        logic [2:0]  f3s  [5] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b000};
        logic [31:0] adrs [5] = '{32'h203, 32'h203, 32'h202, 32'h202, 32'h200};
        logic [31:0] exps [5] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF8011, 32'h00008011,
                                  32'h00000033};
        for (int i = 0; i < 5; i++) begin
            run_access(1'b1, 1'b0, f3s[i], adrs[i], 32'd0, 32'h80112233, i % 2);
            checks++;
            if (o_lr !== exps[i] || o_done_cyc !== 2 + (i % 2)) begin
                errors++;
                $display("FAIL load_ext%0d lr=%h done=%0d exp %h/%0d", i, o_lr, o_done_cyc,
                         exps[i], 2 + (i % 2));
            end
            model_lr = exps[i];
        end
    endtask

    task automatic test_store;
        run_access(1'b0, 1'b1, 3'b000, 32'h301, 32'h000000AB, 32'h5555_5555, 0);
        checks++;
        if (o_wdata !== 32'hABABABAB || o_wstrb !== 4'b0010 || o_we !== 1'b1 ||
            o_addr !== 32'h300) begin
            errors++;
            $display("FAIL sb_bus wdata=%h strb=%b we=%b addr=%h", o_wdata, o_wstrb, o_we, o_addr);
        end
        checks++;
        if (o_lr !== model_lr || o_done_cyc !== 2) begin
            errors++;
            $display("FAIL sb_result lr=%h done=%0d exp %h/2", o_lr, o_done_cyc, model_lr);
        end
        run_access(1'b0, 1'b1, 3'b001, 32'h302, 32'h00001234, 32'd0, 0);
        checks++;
        if (o_wdata !== 32'h12341234 || o_wstrb !== 4'b1100) begin
            errors++;
            $display("FAIL sh_bus wdata=%h strb=%b exp 12341234/1100", o_wdata, o_wstrb);
        end
        run_access(1'b0, 1'b1, 3'b010, 32'h400, 32'hCAFEF00D, 32'd0, 2);
        checks++;
        if (o_wdata !== 32'hCAFEF00D || o_wstrb !== 4'b1111 || o_stable !== 1'b1 ||
            o_valid !== 3 || o_done_cyc !== 4) begin
            errors++;
            $display("FAIL sw_wait wdata=%h strb=%b stable=%b valid=%0d done=%0d", o_wdata,
                     o_wstrb, o_stable, o_valid, o_done_cyc);
        end
    endtask

    task automatic test_misaligned;
        run_access(1'b0, 1'b1, 3'b010, 32'h402, 32'h1, 32'd0, 0);
        checks++;
        if (o_valid !== 0 || o_done_cyc !== 1 || o_mis !== 1'b1 || o_mis_after !== 1'b1) begin
            errors++;
            $display("FAIL sw_misaligned valid=%0d done=%0d mis=%b sticky=%b exp 0/1/1/1",
                     o_valid, o_done_cyc, o_mis, o_mis_after);
        end
        run_access(1'b1, 1'b0, 3'b101, 32'h201, 32'd0, 32'hFFFF_FFFF, 0);
        checks++;
        if (o_valid !== 0 || o_mis !== 1'b1 || o_lr !== model_lr) begin
            errors++;
            $display("FAIL lhu_misaligned valid=%0d mis=%b lr=%h exp 0/1/%h", o_valid, o_mis,
                     o_lr, model_lr);
        end
        run_access(1'b1, 1'b0, 3'b010, 32'h204, 32'd0, 32'h0BADF00D, 0);
        checks++;
        if (o_mis !== 1'b0 || o_lr !== 32'h0BADF00D) begin
            errors++;
            $display("FAIL mis_clear mis=%b lr=%h exp 0/0badf00d", o_mis, o_lr);
        end
        model_lr = 32'h0BADF00D;
    endtask

    task automatic test_timeout;
        run_access(1'b1, 1'b0, 3'b010, 32'h100, 32'd0, 32'h1234_5678, 1000);
        checks++;
        if (o_valid !== TMO || o_done_cyc !== TMO + 1) begin
            errors++;
            $display("FAIL timeout_len valid=%0d done=%0d exp %0d/%0d", o_valid, o_done_cyc,
                     TMO, TMO + 1);
        end
        checks++;
        if (o_berr !== 1'b1 || o_berr_after !== 1'b1 || o_lr !== model_lr) begin
            errors++;
            $display("FAIL timeout_err berr=%b sticky=%b lr=%h exp 1/1/%h", o_berr,
                     o_berr_after, o_lr, model_lr);
        end
        run_access(1'b1, 1'b0, 3'b010, 32'h108, 32'd0, 32'h7777_0001, 3);
        checks++;
        if (o_berr !== 1'b0 || o_lr !== 32'h7777_0001 || o_done_cyc !== 5) begin
            errors++;
            $display("FAIL last_wait berr=%b lr=%h done=%0d exp 0/77770001/5", o_berr, o_lr,
                     o_done_cyc);
        end
        model_lr = 32'h7777_0001;
    endtask

    task automatic test_reset_mid;
        logic saw_done = 1'b0;
        start = 1'b1; is_load = 1'b1; is_store = 1'b0; funct3 = 3'b010;
        address = 32'h700; bus.mem_ready = 1'b0;
        @(posedge clk); #1;
        start = 1'b0; is_load = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.mem_valid, bus.mem_we, bus.mem_wstrb, done, misaligned, bus_err} !== 9'd0 ||
            {bus.mem_addr, bus.mem_wdata, load_result} !== 96'd0) begin
            errors++;
            $display("FAIL reset_mid valid=%b addr=%h lr=%h exp all 0", bus.mem_valid,
                     bus.mem_addr, load_result);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (done) saw_done = 1'b1;
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_lr = 32'd0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (done || bus.mem_valid) saw_done = 1'b1;
        end
        checks++;
        if (saw_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_nodone activity=%b exp 0", saw_done);
        end
        @(posedge clk); #1;
        run_access(1'b1, 1'b0, 3'b010, 32'h704, 32'd0, 32'h00C0FFEE, 0);
        checks++;
        if (o_done_cyc !== 2 || o_lr !== 32'h00C0FFEE) begin
            errors++;
            $display("FAIL after_reset done=%0d lr=%h exp 2/00c0ffee", o_done_cyc, o_lr);
        end
        model_lr = 32'h00C0FFEE;
    endtask

    task automatic test_ignored_start;
        logic act = 1'b0;
        start = 1'b1; is_load = 1'b0; is_store = 1'b0; funct3 = 3'b010; address = 32'h800;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (done || bus.mem_valid) act = 1'b1;
            @(posedge clk); #1;
        end
        start = 1'b0;
        checks++;
        if (act !== 1'b0) begin
            errors++;
            $display("FAIL start_noop activity=%b exp 0", act);
        end
    endtask

    task automatic test_back_to_back;
        logic bad_idle = 1'b0;
        start = 1'b1; is_load = 1'b1; is_store = 1'b0; funct3 = 3'b010; address = 32'h500;
        bus.mem_rdata = 32'h1122_3344; bus.mem_ready = 1'b0;
        @(posedge clk); #1;
        is_load = 1'b0; is_store = 1'b1; address = 32'h600;
        @(negedge clk);
        checks++;
        if (bus.mem_valid !== 1'b1 || bus.mem_addr !== 32'h500 || bus.mem_we !== 1'b0) begin
            errors++;
            $display("FAIL busy_start valid=%b addr=%h we=%b exp 1/500/0", bus.mem_valid,
                     bus.mem_addr, bus.mem_we);
        end
        @(posedge clk); #1;
        bus.mem_ready = 1'b1;
        @(posedge clk); #1;
        bus.mem_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || load_result !== 32'h1122_3344 || bus.mem_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_done done=%b lr=%h valid=%b exp 1/11223344/0", done,
                     load_result, bus.mem_valid);
        end
        model_lr = 32'h1122_3344;
        @(posedge clk); #1;
        start = 1'b0; is_store = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (done || bus.mem_valid) bad_idle = 1'b1;
            @(posedge clk); #1;
        end
        checks++;
        if (bad_idle !== 1'b0) begin
            errors++;
            $display("FAIL start_in_done activity=%b exp 0", bad_idle);
        end
    endtask

    task automatic test_random;
        for (int i = 0; i < 60; i++) begin
            logic        ld   = 1'($urandom_range(0, 1));
            logic [2:0]  f3   = 3'($urandom_range(0, 7));
            logic [31:0] addr = $urandom;
            logic [31:0] sd   = $urandom;
            logic [31:0] rd   = $urandom;
            int          r    = int'($urandom_range(0, 9));
            int          waits = (r < 7) ? (r % 4) : 6;
            logic        mis  = exp_mis(f3, addr);
            logic        tmo  = !mis && (waits >= TMO);
            int          ev   = mis ? 0 : (tmo ? TMO : waits + 1);
            int          ed   = mis ? 1 : ev + 1;
            run_access(ld, !ld, f3, addr, sd, rd, waits);
            if (ld && !mis && !tmo) model_lr = exp_load(f3, addr, rd);
            checks++;
            if (o_valid !== ev || o_done_cyc !== ed || o_done_after !== 1'b0) begin
                errors++;
                $display("FAIL rnd%0d timing valid=%0d done=%0d after=%b exp %0d/%0d/0", i,
                         o_valid, o_done_cyc, o_done_after, ev, ed);
            end
            checks++;
            if (o_mis !== mis || o_berr !== tmo || o_lr !== model_lr) begin
                errors++;
                $display("FAIL rnd%0d status mis=%b berr=%b lr=%h exp %b/%b/%h", i, o_mis,
                         o_berr, o_lr, mis, tmo, model_lr);
            end
            if (!mis) begin
                checks++;
                if (o_addr !== {addr[31:2], 2'b00} || o_we !== !ld || o_stable !== 1'b1 ||
                    o_wstrb !== (ld ? 4'b0000 : exp_strb(f3, addr)) ||
                    (!ld && o_wdata !== exp_wdata(f3, sd))) begin
                    errors++;
                    $display("FAIL rnd%0d bus addr=%h we=%b strb=%b wdata=%h stable=%b f3=%0d a=%h",
                             i, o_addr, o_we, o_wstrb, o_wdata, o_stable, f3, addr);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_lw();
        test_load_ext();
        test_store();
        test_misaligned();
        test_timeout();
        test_reset_mid();
        test_ignored_start();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
